// File: rtl/message_rx_deframer_pkg.sv
// rtl/message_rx_deframer_pkg.sv - shared FSM states and defaults for the serial message deframer
package message_rx_deframer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int         TRAILER_W          = 4;
    localparam logic [3:0] DEFAULT_TRAILER    = 4'b0101;
    localparam int         DEFAULT_BIT_CYCLES = 1024;

    function automatic int frame_width(input int msg_w);
        return msg_w + TRAILER_W;
    endfunction

endpackage

// File: rtl/message_rx_deframer_counter.sv
// rtl/message_rx_deframer_counter.sv - parameterised wrapping counter used as the bit-phase timer
module message_rx_deframer_counter #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == MAX) ? '0 : count + WIDTH'(1);
        end
    end

    // clear wins over en, so a wrap is only reported when the count really rolls over
    assign wrap = en && !clear && (count == MAX);

endmodule

// File: rtl/message_rx_deframer.sv
// rtl/message_rx_deframer.sv - serial frame receiver: payload + fixed trailer, LSB first
// Optional err_cnt output enabled by defining MSG_RX_ERR_CNT_EN.
module message_rx_deframer
    import message_rx_deframer_pkg::*;
#(
    parameter int                    BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int                    MSG_W      = 5,
    parameter logic [TRAILER_W-1:0]  TRAILER    = DEFAULT_TRAILER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             SerIn,
    output logic [MSG_W-1:0] msg_out,
    output logic             msg_valid,
    output logic             frame_err,
    output logic             busy
`ifdef MSG_RX_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int              FW        = frame_width(MSG_W);
    localparam int              PH_W      = $clog2(BIT_CYCLES);
    localparam int              BI_W      = $clog2(FW);
    localparam logic [PH_W-1:0] PH_MAX    = PH_W'(BIT_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(BIT_CYCLES / 2 - 1);
    localparam logic [BI_W-1:0] LAST_BIT  = BI_W'(FW - 1);

    state_t          state;
    logic [BI_W-1:0] bit_idx;
    logic [FW-1:0]   shreg;
    logic [PH_W-1:0] phase;
    logic            phase_clear;
    logic            phase_en;
    logic            phase_wrap;
    logic            sample;

    // Phase is held at zero outside RECV so the first RECV cycle after start is phase 0
    assign phase_clear = start || (state != RECV);
    assign phase_en    = (state == RECV);

    message_rx_deframer_counter #(
        .WIDTH (PH_W),
        .MAX   (PH_MAX)
    ) u_phase (
        .clk   (clk),
        .reset (reset),
        .clear (phase_clear),
        .en    (phase_en),
        .count (phase),
        .wrap  (phase_wrap)
    );

    assign sample = phase_en && !start && (phase == PH_SAMPLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shreg     <= '0;
            msg_out   <= '0;
            msg_valid <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                // start in any state (re)begins reception; an aborted frame yields no pulse
                state   <= RECV;
                bit_idx <= '0;
                shreg   <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RECV: begin
                        if (sample) begin
                            shreg <= {SerIn, shreg[FW-1:1]};
                        end
                        if (phase_wrap) begin
                            if (bit_idx == LAST_BIT) begin
                                state <= CHECK;
                            end else begin
                                bit_idx <= bit_idx + BI_W'(1);
                            end
                        end
                    end
                    CHECK: begin
                        if (shreg[FW-1:MSG_W] == TRAILER) begin
                            msg_out   <= shreg[MSG_W-1:0];
                            msg_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state   <= IDLE;
                        bit_idx <= '0;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MSG_RX_ERR_CNT_EN
    // Saturating count of trailer mismatches; survives start, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (frame_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
